serial_frame_deser: RTL and testbench
=====================================

# serial_frame_deser

Parametrised serial-to-parallel frame deserialiser for the receive datapath. It collects bit-strobed serial data into NDATA-bit frames and finds frame alignment from a start-of-frame flag instead of an external counter. Completed frames go into a double-buffered holding register with a valid/ready handshake. An optional symbol-rotate function realigns the held frame in SYM_W-bit steps.

## Interface
- NDATA, 128, frame width in bits; ≥ 2·SYM_W and an integer multiple of SYM_W.
- SYM_W, 4, rotate step in bits.
- MSB_FIRST, 1, 1: first received bit lands in dout[NDATA-1]; 0: first bit lands in dout[0].

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- din  in  1  serial data bit.
- din_vld  in  1  din strobe; one bit accepted per cycle with din_vld=1.
- sof  in  1  start-of-frame; qualified by din_vld; marks din as bit 0 of a frame.
- dout  out  NDATA  held frame.
- dout_vld  out  1  dout holds an unconsumed frame.
- dout_rdy  in  1  consumer accepts dout when dout_vld=1.
- rot_req  in  1  rotate held frame left by SYM_W (feature-gated).
- bit_cnt  out  $clog2(NDATA)  bits accepted in the current frame.
- ovf  out  1  sticky overflow: a frame was dropped.
- ovf_clr  in  1  synchronous clear of ovf.

## Operation
- FSM states: HUNT, FILL.
- HUNT: bits with din_vld=1 and sof=0 are discarded; bit_cnt=0. A bit with din_vld=1 and sof=1 is accepted as bit 0: bit_cnt←1, go to FILL.
- FILL: each din_vld=1 bit is shifted into the shift register.
  - MSB_FIRST=1: shift left, new bit at LSB.
  - MSB_FIRST=0: shift right, new bit at MSB.
  - bit_cnt increments.
- sof=1 with din_vld=1 in FILL: resync. The partial frame is discarded, the bit becomes bit 0, bit_cnt←1, no flag raised.
- Frame complete: a bit is accepted while bit_cnt=NDATA-1.
  - The assembled word (shift register plus the current din) is offered to the holding register on that same edge.
  - bit_cnt←0; FSM stays in FILL for back-to-back frames, so the next bit is bit 0 without sof.
- Holding register load:
  - Load if dout_vld=0, or if dout_vld=1 and dout_rdy=1 in the same cycle. dout_vld stays 1.
  - Otherwise the new frame is dropped, dout is unchanged and ovf←1.
- Consume: dout_vld=1 and dout_rdy=1 with no load in the same cycle → dout_vld←0; dout keeps its value.
- Rotate (see Configuration): rot_req=1, dout_vld=1, no consume and no load in the same cycle → dout ← {dout[NDATA-SYM_W-1:0], dout[NDATA-1:NDATA-SYM_W]}. Ignored when dout_vld=0.
- Priority on dout: load > consume > rotate.
- ovf: set by a drop, cleared by ovf_clr; a drop in the same cycle as ovf_clr wins (ovf stays 1).

## Timing
- Reset values: dout=0, dout_vld=0, bit_cnt=0, ovf=0, shift register=0, FSM=HUNT.
- Latency: last bit strobed in cycle N → dout and dout_vld valid in cycle N+1.
- Throughput: one frame per NDATA strobes with no idle cycles required; the consumer must accept within NDATA strobes to avoid overflow.
- Handshake: dout_vld stays high until a transfer; dout is stable while dout_vld=1 and no rotate is issued.
- Reset mid-frame: the partial frame and the held frame are lost; after release, hunt for sof.
- din_vld=0 cycles: no state change in the FSM, shift register or bit_cnt.

## Configuration
- SERIAL_FRAME_DESER_ROT_EN defined: rot_req is honoured as above.
- SERIAL_FRAME_DESER_ROT_EN undefined:
  - rot_req is ignored and there is no rotate mux.
  - dout changes only on load or reset.

## Test plan
Bench uses NDATA=16, SYM_W=4, MSB_FIRST=1 unless stated.
- After reset, send 0xA5C3 MSB first with sof on bit 0 and dout_rdy=1 → dout=0xA5C3, dout_vld=1 one cycle after the 16th strobe, and dout_vld=0 the cycle after that.
- 5 bits without sof, then a frame 0x1234 with sof → prefix discarded, dout=0x1234.
- Resync: sof at bit 7 of a partial frame, followed by 0xBEEF → dout=0xBEEF, ovf=0.
- dout_rdy=0, two back-to-back frames 0x1111 and 0x2222 → dout=0x1111 and ovf=1; ovf_clr pulse → ovf=0.
- ROT_EN defined, dout=0x1234 held, two rot_req pulses → 0x2341 then 0x3412; undefined → dout stays 0x1234.
- MSB_FIRST=0, bits 1,0,0,…,0 → dout=0x0001.

Source files
------------

// File: rtl/serial_frame_deser.sv
// serial_frame_deser: sof-aligned serial-to-parallel deserialiser with a valid/ready holding register.
// Define SERIAL_FRAME_DESER_ROT_EN to enable the SYM_W-step rotate of the held frame.
module serial_frame_deser #(
  parameter int NDATA     = 128,
  parameter int SYM_W     = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din,
  input  logic                     din_vld,
  input  logic                     sof,
  output logic [NDATA-1:0]         dout,
  output logic                     dout_vld,
  input  logic                     dout_rdy,
  input  logic                     rot_req,
  output logic [$clog2(NDATA)-1:0] bit_cnt,
  output logic                     ovf,
  input  logic                     ovf_clr
);
  localparam int CW = $clog2(NDATA);
  localparam logic [CW-1:0] LAST = CW'(NDATA - 1);
  typedef enum logic {HUNT, FILL} state_t;
  state_t state_q, state_d;
  logic [NDATA-1:0] sh_q, sh_d, dout_q, dout_d, word, first;
  logic [CW-1:0] cnt_q, cnt_d;
  logic vld_q, vld_d, ovf_q, ovf_d, acc, done, load, drop, consume;
  always_comb begin
    word    = MSB_FIRST ? {sh_q[NDATA-2:0], din} : {din, sh_q[NDATA-1:1]};
    first   = MSB_FIRST ? NDATA'(din) : {din, {(NDATA-1){1'b0}}};
    acc     = din_vld && (sof || state_q == FILL);
    // sof always restarts the frame, even on what would have been the last bit
    done    = din_vld && !sof && state_q == FILL && cnt_q == LAST;
    load    = done && (!vld_q || dout_rdy);
    drop    = done && vld_q && !dout_rdy;
    consume = vld_q && dout_rdy && !load;
    state_d = acc ? FILL : state_q;
    sh_d    = !acc ? sh_q : sof ? first : word;
    cnt_d   = !acc ? cnt_q : sof ? CW'(1) : done ? '0 : cnt_q + 1'b1;
    vld_d   = load || (vld_q && !consume);
    ovf_d   = drop || (ovf_q && !ovf_clr);
`ifdef SERIAL_FRAME_DESER_ROT_EN
    dout_d  = load ? word :
              (rot_req && vld_q && !consume) ? {dout_q[NDATA-SYM_W-1:0], dout_q[NDATA-1:NDATA-SYM_W]} :
              dout_q;
`else
    dout_d  = load ? word : dout_q;
`endif
  end
`ifndef SERIAL_FRAME_DESER_ROT_EN
  logic rot_unused;
  assign rot_unused = rot_req;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      sh_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end
  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign bit_cnt  = cnt_q;
  assign ovf      = ovf_q;
endmodule

// File: tb/tb_serial_frame_deser.sv
// tb_serial_frame_deser: directed checks of serial_frame_deser with MSB-first and LSB-first instances.
module tb_serial_frame_deser;
  logic clk = 0, rst = 0, din = 0, din_vld = 0, sof = 0, dout_rdy = 0, rot_req = 0, ovf_clr = 0;
  logic [15:0] dout0, dout1;
  logic vld0, vld1, ovf0, ovf1;
  logic [3:0] cnt0, cnt1;
  int checks = 0, errors = 0;
  typedef struct {
    logic [15:0] w;
    int          pre;
    logic        gap;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;
  vec_t tbl[4];
  always #5 clk = ~clk;
  serial_frame_deser #(.NDATA(16), .SYM_W(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .sof(sof),
    .dout(dout0), .dout_vld(vld0), .dout_rdy(dout_rdy), .rot_req(rot_req),
    .bit_cnt(cnt0), .ovf(ovf0), .ovf_clr(ovf_clr)
  );
  serial_frame_deser #(.NDATA(16), .SYM_W(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .sof(sof),
    .dout(dout1), .dout_vld(vld1), .dout_rdy(dout_rdy), .rot_req(rot_req),
    .bit_cnt(cnt1), .ovf(ovf1), .ovf_clr(ovf_clr)
  );
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic step(input logic b, input logic v, input logic s, input logic r, input logic rot, input logic clr);
    din = b; din_vld = v; sof = s; dout_rdy = r; rot_req = rot; ovf_clr = clr;
    @(posedge clk); #1;
    din_vld = 0; sof = 0; rot_req = 0; ovf_clr = 0;
  endtask
  task automatic send_frame(input logic [15:0] w, input logic s0, input logic rb, input logic rl,
                            input logic gap, input logic cl);
    for (int i = 0; i < 16; i++) begin
      step(w[15-i], 1'b1, (i == 0) && s0, (i == 15) ? rl : rb, 1'b0, (i == 15) ? cl : 1'b0);
      chk("bit_cnt", 16'(cnt0), 16'((i + 1) % 16));
      if (gap && i < 15) begin
        step(1'b1, 1'b0, 1'b0, rb, 1'b0, 1'b0);
        chk("gap_cnt", 16'(cnt0), 16'(i + 1));
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{16'hA5C3, 0, 1'b0, 16'hA5C3, 16'hC3A5};
    tbl[1] = '{16'h1234, 5, 1'b0, 16'h1234, 16'h2C48};
    tbl[2] = '{16'hBEEF, 7, 1'b1, 16'hBEEF, 16'hF77D};
    tbl[3] = '{16'h8000, 3, 1'b0, 16'h8000, 16'h0001};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout0, 16'h0);
    chk("rst_vld", 16'(vld0), 16'h0);
    chk("rst_cnt", 16'(cnt0), 16'h0);
    chk("rst_ovf", 16'(ovf0), 16'h0);
    rst = 1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("hunt_cnt", 16'(cnt0), 16'h0);
    end
    send_frame(16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hunt_dout", dout0, 16'h1234);
    chk("hunt_vld", 16'(vld0), 16'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("hunt_consume", 16'(vld0), 16'h0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < tbl[k].pre; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(tbl[k].w, 1'b1, 1'b1, 1'b1, tbl[k].gap, 1'b0);
      chk("tbl_dout_msb", dout0, tbl[k].exp0);
      chk("tbl_dout_lsb", dout1, tbl[k].exp1);
      chk("tbl_vld", 16'(vld0), 16'h1);
      chk("tbl_ovf", 16'(ovf0), 16'h0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("tbl_consume", 16'(vld0), 16'h0);
      chk("tbl_hold", dout0, tbl[k].exp0);
    end
    send_frame(16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_first", dout0, 16'h1111);
    chk("ovf_first_ovf", 16'(ovf0), 16'h0);
    send_frame(16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_keep", dout0, 16'h1111);
    chk("ovf_set", 16'(ovf0), 16'h1);
    chk("ovf_vld", 16'(vld0), 16'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 16'(ovf0), 16'h0);
    send_frame(16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ldcons_dout", dout0, 16'h1234);
    chk("ldcons_vld", 16'(vld0), 16'h1);
    chk("ldcons_ovf", 16'(ovf0), 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SERIAL_FRAME_DESER_ROT_EN
    chk("rot1_msb", dout0, 16'h2341);
    chk("rot1_lsb", dout1, 16'hC482);
`else
    chk("rot1_msb", dout0, 16'h1234);
    chk("rot1_lsb", dout1, 16'h2C48);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SERIAL_FRAME_DESER_ROT_EN
    chk("rot2_msb", dout0, 16'h3412);
    chk("rot2_lsb", dout1, 16'h482C);
`else
    chk("rot2_msb", dout0, 16'h1234);
    chk("rot2_lsb", dout1, 16'h2C48);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rot_consume", 16'(vld0), 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SERIAL_FRAME_DESER_ROT_EN
    chk("rot_idle", dout0, 16'h3412);
`else
    chk("rot_idle", dout0, 16'h1234);
`endif
    send_frame(16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_load", dout0, 16'h5555);
    send_frame(16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("drop_clr_ovf", 16'(ovf0), 16'h1);
    chk("drop_clr_dout", dout0, 16'h5555);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("drop_clr2", 16'(ovf0), 16'h0);
    chk("drop_consume", 16'(vld0), 16'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, i == 0, 1'b1, 1'b0, 1'b0);
    chk("mid_cnt", 16'(cnt0), 16'h8);
    rst = 0;
    #1;
    chk("arst_cnt", 16'(cnt0), 16'h0);
    chk("arst_dout", dout0, 16'h0);
    chk("arst_vld", 16'(vld0), 16'h0);
    @(posedge clk);
    #1;
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("post_rst_hunt", 16'(cnt0), 16'h0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
